// File: rtl/axi_icache_sa_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_icache_sa_if                                                |
// | Brief    : AXI4 read-only bus (AR + R channels) used on both cache sides.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface axi_icache_sa_if #(
    parameter int XLEN = 32
) ();
    logic            arvalid;
    logic            arready;
    logic [XLEN-1:0] araddr;
    logic [3:0]      arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [3:0]      rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface
`default_nettype wire

// File: rtl/axi_icache_sa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_icache_sa                                                   |
// | Brief    : Set-associative, round-robin, error-aware AXI4 instruction      |
// |            cache. Define ICACHE_FLUSH_EN to enable i_flush invalidate-all. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module axi_icache_sa #(
    parameter int XLEN       = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    input  wire logic       i_flush,
    axi_icache_sa_if.slave  ifu,
    axi_icache_sa_if.master mem
);
    localparam int c_bb     = XLEN / 8;
    localparam int c_bb_w   = $clog2(c_bb);
    localparam int c_off_w  = $clog2(LINE_BYTES);
    localparam int c_idx_w  = $clog2(SETS);
    localparam int c_tag_w  = XLEN - c_off_w - c_idx_w;
    localparam int c_words  = LINE_BYTES / c_bb;
    localparam int c_word_w = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int c_way_w  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0]         c_size_max = 3'(c_bb_w);
    localparam logic [7:0]         c_arlen    = 8'(c_words - 1);
    localparam logic [XLEN-1:0]    c_addr_one = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [c_way_w-1:0] c_last_way = c_way_w'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MISS_AR = 3'd2,
        S_REFILL  = 3'd3,
`ifdef ICACHE_FLUSH_EN
        S_RESP    = 3'd4,
        S_FLUSH   = 3'd5
`else
        S_RESP    = 3'd4
`endif
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_id;
    logic [XLEN-1:0]       r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [c_way_w-1:0]    r_way;
    logic [c_word_w-1:0]   r_wcnt;
    logic                  r_refill_err;

    logic [c_tag_w-1:0]    r_tag  [WAYS][SETS];
    logic [XLEN-1:0]       r_data [WAYS][SETS][c_words];
    logic [SETS-1:0]       r_valid [WAYS];
    logic [c_way_w-1:0]    r_vptr [SETS];

    logic [c_idx_w-1:0]    w_idx;
    logic [c_tag_w-1:0]    w_tag;
    logic [c_word_w-1:0]   w_word;
    logic [WAYS-1:0]       w_hit_vec;
    logic                  w_hit;
    logic [c_way_w-1:0]    w_hit_way;
    logic                  w_inv_found;
    logic [c_way_w-1:0]    w_inv_way;
    logic [c_way_w-1:0]    w_victim;
    logic [c_way_w-1:0]    w_vptr_next;
    logic [XLEN-1:0]       w_next_addr;
    logic                  w_line_cross;
    logic                  w_line_err;
    logic                  w_ar_hs;
    logic                  w_refill_beat;
    logic                  w_refill_done;
    logic                  w_arready;
    logic                  w_rvalid;
    logic                  w_mem_arvalid;
    logic                  w_mem_rready;
    logic                  w_flush_pend;
    logic                  w_unused_ok;

    assign w_idx = r_addr[c_off_w +: c_idx_w];
    assign w_tag = r_addr[XLEN-1 -: c_tag_w];

    if (c_words > 1) begin : g_multi_word
        assign w_word = r_addr[c_off_w-1:c_bb_w];
    end else begin : g_single_word
        assign w_word = '0;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_tag_cmp
        assign w_hit_vec[g] = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
    end

    // Descending scan so the lowest-numbered way wins both searches.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_w'(w);
            end
            if (!r_valid[w][w_idx]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_way_w'(w);
            end
        end
    end

    assign w_victim      = w_inv_found ? w_inv_way : r_vptr[w_idx];
    assign w_vptr_next   = (r_vptr[w_idx] == c_last_way) ? '0 : r_vptr[w_idx] + c_way_w'(1);
    assign w_next_addr   = (r_burst == 2'b00) ? r_addr : r_addr + (c_addr_one << r_size);
    assign w_line_cross  = w_next_addr[XLEN-1:c_off_w] != r_addr[XLEN-1:c_off_w];
    assign w_line_err    = r_refill_err | (mem.rresp != 2'b00);
    assign w_ar_hs       = ifu.arvalid & w_arready;
    assign w_refill_beat = (r_state == S_REFILL) & mem.rvalid;
    assign w_refill_done = w_refill_beat & mem.rlast;

`ifdef ICACHE_FLUSH_EN
    logic r_flush_pend;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_flush_pend <= 1'b0;
        end else if (i_flush) begin
            r_flush_pend <= 1'b1;
        end else if (r_state == S_FLUSH) begin
            r_flush_pend <= 1'b0;
        end
    end
    assign w_flush_pend = r_flush_pend;
    assign w_unused_ok  = ^{1'b0, mem.rid};
`else
    assign w_flush_pend = 1'b0;
    assign w_unused_ok  = ^{1'b0, mem.rid, i_flush, w_flush_pend};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_arready     = 1'b0;
        w_rvalid      = 1'b0;
        w_mem_arvalid = 1'b0;
        w_mem_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef ICACHE_FLUSH_EN
                if (w_flush_pend) begin
                    w_next = S_FLUSH;
                end else begin
                    w_arready = 1'b1;
                    if (ifu.arvalid) w_next = S_LOOKUP;
                end
`else
                w_arready = 1'b1;
                if (ifu.arvalid) w_next = S_LOOKUP;
`endif
            end
            S_LOOKUP:  w_next = w_hit ? S_RESP : S_MISS_AR;
            S_MISS_AR: begin
                w_mem_arvalid = 1'b1;
                if (mem.arready) w_next = S_REFILL;
            end
            S_REFILL: begin
                w_mem_rready = 1'b1;
                if (mem.rvalid && mem.rlast) w_next = S_RESP;
            end
            S_RESP: begin
                w_rvalid = 1'b1;
                if (ifu.rready) begin
                    if (r_len == 8'd0)     w_next = S_IDLE;
                    else if (w_line_cross) w_next = S_LOOKUP;
                end
            end
`ifdef ICACHE_FLUSH_EN
            S_FLUSH:   w_next = S_IDLE;
`endif
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_err        <= 1'b0;
            r_way        <= '0;
            r_wcnt       <= '0;
            r_refill_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_err <= 1'b0;
            if (w_ar_hs) begin
                r_id    <= ifu.arid;
                r_addr  <= ifu.araddr;
                r_len   <= ifu.arlen;
                r_burst <= ifu.arburst;
                r_size  <= (ifu.arsize > c_size_max) ? c_size_max : ifu.arsize;
            end
            if (r_state == S_LOOKUP) r_way <= w_hit ? w_hit_way : w_victim;
            if (r_state == S_MISS_AR && mem.arready) begin
                r_wcnt       <= '0;
                r_refill_err <= 1'b0;
            end
            if (w_refill_beat) begin
                r_wcnt       <= r_wcnt + c_word_w'(1);
                r_refill_err <= w_line_err;
            end
            if (w_refill_done && w_line_err) r_err <= 1'b1;
            if (r_state == S_RESP && ifu.rready && r_len != 8'd0) begin
                r_addr <= w_next_addr;
                r_len  <= r_len - 8'd1;
            end
        end
    end

    // The victim is invalidated before its data is overwritten, so an
    // aborted or errored refill can never expose a stale-tag hit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_vptr[s] <= '0;
        end else begin
            if (r_state == S_MISS_AR && mem.arready) r_valid[r_way][w_idx] <= 1'b0;
            if (w_refill_done && !w_line_err) begin
                r_valid[r_way][w_idx] <= 1'b1;
                r_vptr[w_idx]         <= w_vptr_next;
            end
`ifdef ICACHE_FLUSH_EN
            if (r_state == S_FLUSH) begin
                for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                for (int s = 0; s < SETS; s++) r_vptr[s] <= '0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_refill_beat) r_data[r_way][w_idx][r_wcnt] <= mem.rdata;
        if (w_refill_done && !w_line_err) r_tag[r_way][w_idx] <= w_tag;
    end

    assign ifu.arready = w_arready & i_rst_n;
    assign ifu.rvalid  = w_rvalid;
    assign ifu.rdata   = w_rvalid ? r_data[r_way][w_idx][w_word] : '0;
    assign ifu.rresp   = (w_rvalid && r_err) ? 2'b10 : 2'b00;
    assign ifu.rlast   = w_rvalid && (r_len == 8'd0);
    assign ifu.rid     = w_rvalid ? r_id : '0;

    assign mem.arvalid = w_mem_arvalid;
    assign mem.araddr  = w_mem_arvalid ? {r_addr[XLEN-1:c_off_w], {c_off_w{1'b0}}} : '0;
    assign mem.arlen   = w_mem_arvalid ? c_arlen : '0;
    assign mem.arsize  = w_mem_arvalid ? c_size_max : '0;
    assign mem.arburst = w_mem_arvalid ? 2'b01 : 2'b00;
    assign mem.arid    = w_mem_arvalid ? r_id : '0;
    assign mem.rready  = w_mem_rready;
endmodule
`default_nettype wire

// File: tb/tb_axi_icache_sa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_icache_sa                                                |
// | Brief    : Scoreboard bench for axi_icache_sa; memory returns ~addr.       |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_axi_icache_sa;
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
    } mar_t;

    logic clk;
    logic rst_n;
    logic i_flush;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_mar = 0;
    int   mar_cyc = 0;
    int   rlast_cyc = 0;
    int   first_rv_cyc = 0;
    int   last_pop_cyc = 0;
    int   ar_cyc = 0;
    int   stall_left = 0;
    int   err_beat = -1;
    int   flush_beat = -1;
    bit   rv_seen = 1'b0;
    rbeat_t exp_r[$];
    mar_t   exp_mar[$];

    axi_icache_sa_if #(.XLEN(32)) ifu_bus ();
    axi_icache_sa_if #(.XLEN(32)) mem_bus ();

    axi_icache_sa #(.XLEN(32), .LINE_BYTES(16), .SETS(16), .WAYS(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (i_flush),
        .ifu     (ifu_bus),
        .mem     (mem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        rbeat_t b;
        b.data = d; b.resp = r; b.last = l; b.id = id;
        exp_r.push_back(b);
    endtask

    task automatic exp_ar(input logic [31:0] a, input logic [3:0] id);
        mar_t m;
        m.addr = a; m.id = id;
        exp_mar.push_back(m);
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [3:0] id);
        int g = 0;
        @(negedge clk);
        rv_seen          = 1'b0;
        ifu_bus.arvalid  = 1'b1;
        ifu_bus.araddr   = a;
        ifu_bus.arlen    = len;
        ifu_bus.arsize   = sz;
        ifu_bus.arburst  = bu;
        ifu_bus.arid     = id;
        while (ifu_bus.arready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("ar_accepted", 32'(g < 100), 32'd1);
        ar_cyc = cyc;
        @(negedge clk);
        ifu_bus.arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while ((exp_r.size() != 0 || exp_mar.size() != 0 || ifu_bus.rvalid === 1'b1) && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("drain_in_time", 32'(g < 400), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // R-channel monitor: sole driver of ifu rready, pops the scoreboard per accepted beat.
    initial begin : r_monitor
        rbeat_t      e;
        logic [31:0] held_data;
        bit          held_valid;
        held_valid     = 1'b0;
        held_data      = '0;
        ifu_bus.rready = 1'b0;
        forever begin
            @(negedge clk);
            if (ifu_bus.rvalid === 1'b1) begin
                if (!rv_seen) begin
                    rv_seen      = 1'b1;
                    first_rv_cyc = cyc;
                end
                if (held_valid) chk("stall_rdata_stable", ifu_bus.rdata, held_data);
                if (stall_left > 0) begin
                    stall_left--;
                    ifu_bus.rready = 1'b0;
                    held_data      = ifu_bus.rdata;
                    held_valid     = 1'b1;
                end else begin
                    ifu_bus.rready = 1'b1;
                    held_valid     = 1'b0;
                    last_pop_cyc   = cyc;
                    chk("beat_expected", 32'(exp_r.size() > 0), 32'd1);
                    if (exp_r.size() > 0) begin
                        e = exp_r.pop_front();
                        chk("rdata", ifu_bus.rdata, e.data);
                        chk("rresp", 32'(ifu_bus.rresp), 32'(e.resp));
                        chk("rlast", 32'(ifu_bus.rlast), 32'(e.last));
                        chk("rid", 32'(ifu_bus.rid), 32'(e.id));
                    end
                end
            end else begin
                ifu_bus.rready = 1'b0;
                held_valid     = 1'b0;
            end
        end
    end

    // Memory model: checks each refill AR, then returns 4 beats of ~addr.
    initial begin : mem_model
        mar_t        m;
        logic [31:0] base;
        bit          hs;
        int          k;
        int          g;
        mem_bus.arready = 1'b0;
        mem_bus.rvalid  = 1'b0;
        mem_bus.rdata   = '0;
        mem_bus.rresp   = 2'b00;
        mem_bus.rlast   = 1'b0;
        mem_bus.rid     = 4'h0;
        i_flush         = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_bus.arvalid === 1'b1) begin
                mar_cyc = cyc;
                n_mar++;
                chk("mar_expected", 32'(exp_mar.size() > 0), 32'd1);
                if (exp_mar.size() > 0) begin
                    m = exp_mar.pop_front();
                    chk("mem_araddr", mem_bus.araddr, m.addr);
                    chk("mem_arlen", 32'(mem_bus.arlen), 32'd3);
                    chk("mem_arsize", 32'(mem_bus.arsize), 32'd2);
                    chk("mem_arburst", 32'(mem_bus.arburst), 32'd1);
                    chk("mem_arid", 32'(mem_bus.arid), 32'(m.id));
                end
                base            = mem_bus.araddr;
                mem_bus.arready = 1'b1;
                @(negedge clk);
                mem_bus.arready = 1'b0;
                k = 0;
                g = 0;
                while (k < 4 && g < 50) begin
                    mem_bus.rvalid = 1'b1;
                    mem_bus.rdata  = ~(base + 32'(4 * k));
                    mem_bus.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
                    mem_bus.rlast  = (k == 3);
                    mem_bus.rid    = 4'hF;
                    i_flush        = (k == flush_beat);
                    hs             = (mem_bus.rready === 1'b1);
                    if (hs && k == 3) rlast_cyc = cyc;
                    @(negedge clk);
                    i_flush = 1'b0;
                    if (hs) k++;
                    g++;
                end
                chk("refill_in_time", 32'(g < 50), 32'd1);
                mem_bus.rvalid = 1'b0;
                mem_bus.rlast  = 1'b0;
                mem_bus.rresp  = 2'b00;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion want summary by 50000 cycles");
        $fatal(1);
    end

    initial begin : stimulus
        int nm;
        rst_n           = 1'b0;
        ifu_bus.arvalid = 1'b0;
        ifu_bus.araddr  = '0;
        ifu_bus.arlen   = '0;
        ifu_bus.arsize  = '0;
        ifu_bus.arburst = '0;
        ifu_bus.arid    = '0;
        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(ifu_bus.arready), 32'd0);
        chk("rst_rvalid", 32'(ifu_bus.rvalid), 32'd0);
        chk("rst_mem_arvalid", 32'(mem_bus.arvalid), 32'd0);
        chk("rst_mem_rready", 32'(mem_bus.rready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_arready", 32'(ifu_bus.arready), 32'd1);

        // Cold miss, single beat from mid-line.
        exp_ar(32'h8000_0000, 4'd3);
        exp_beat(32'h7FFF_FFFB, 2'b00, 1'b1, 4'd3);
        issue_ar(32'h8000_0004, 8'd0, 3'd2, 2'b01, 4'd3);
        wait_done();
        chk("miss_mar_latency", 32'(mar_cyc), 32'(ar_cyc + 2));
        chk("miss_rv_latency", 32'(first_rv_cyc), 32'(rlast_cyc + 1));

        // Hit on the same line.
        nm = n_mar;
        exp_beat(32'h7FFF_FFF7, 2'b00, 1'b1, 4'd5);
        issue_ar(32'h8000_0008, 8'd0, 3'd2, 2'b01, 4'd5);
        wait_done();
        chk("hit_rv_latency", 32'(first_rv_cyc), 32'(ar_cyc + 2));
        chk("hit_no_mem_ar", 32'(n_mar), 32'(nm));

        // Conflict in set 0: B fills way 1, C evicts way 0 (A).
        exp_ar(32'h8000_1000, 4'd1);
        exp_beat(32'h7FFF_EFFB, 2'b00, 1'b1, 4'd1);
        issue_ar(32'h8000_1004, 8'd0, 3'd2, 2'b01, 4'd1);
        wait_done();
        exp_ar(32'h8000_2000, 4'd2);
        exp_beat(32'h7FFF_DFF7, 2'b00, 1'b1, 4'd2);
        issue_ar(32'h8000_2008, 8'd0, 3'd2, 2'b01, 4'd2);
        wait_done();
        nm = n_mar;
        exp_beat(32'h7FFF_EFF3, 2'b00, 1'b1, 4'd4);
        issue_ar(32'h8000_100C, 8'd0, 3'd2, 2'b01, 4'd4);
        wait_done();
        chk("b_still_hits", 32'(n_mar), 32'(nm));
        exp_ar(32'h8000_0000, 4'd6);
        exp_beat(32'h7FFF_FFFF, 2'b00, 1'b1, 4'd6);
        issue_ar(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd6);
        wait_done();
        chk("a_missed", 32'(n_mar), 32'(nm + 1));

        // INCR burst crossing into line 0x8000_0010.
        exp_ar(32'h8000_0010, 4'd7);
        exp_beat(32'h7FFF_FFF3, 2'b00, 1'b0, 4'd7);
        exp_beat(32'h7FFF_FFEF, 2'b00, 1'b0, 4'd7);
        exp_beat(32'h7FFF_FFEB, 2'b00, 1'b0, 4'd7);
        exp_beat(32'h7FFF_FFE7, 2'b00, 1'b1, 4'd7);
        issue_ar(32'h8000_000C, 8'd3, 3'd2, 2'b01, 4'd7);
        wait_done();

        // Refill error on beat 2, then the same line misses again.
        err_beat = 2;
        exp_ar(32'h8000_3000, 4'd8);
        exp_beat(32'h7FFF_CFFB, 2'b10, 1'b1, 4'd8);
        issue_ar(32'h8000_3004, 8'd0, 3'd2, 2'b01, 4'd8);
        wait_done();
        err_beat = -1;
        nm = n_mar;
        exp_ar(32'h8000_3000, 4'd9);
        exp_beat(32'h7FFF_CFFB, 2'b00, 1'b1, 4'd9);
        issue_ar(32'h8000_3004, 8'd0, 3'd2, 2'b01, 4'd9);
        wait_done();
        chk("err_line_refetched", 32'(n_mar), 32'(nm + 1));

        // Back-pressure: rready low for 5 cycles on a hit.
        stall_left = 5;
        exp_beat(32'h7FFF_FFF7, 2'b00, 1'b1, 4'd10);
        issue_ar(32'h8000_0008, 8'd0, 3'd2, 2'b01, 4'd10);
        wait_done();

        // FIXED burst: three beats of the same word, one per cycle.
        exp_beat(32'h7FFF_FFEB, 2'b00, 1'b0, 4'd11);
        exp_beat(32'h7FFF_FFEB, 2'b00, 1'b0, 4'd11);
        exp_beat(32'h7FFF_FFEB, 2'b00, 1'b1, 4'd11);
        issue_ar(32'h8000_0014, 8'd2, 3'd2, 2'b00, 4'd11);
        wait_done();
        chk("fixed_burst_rate", 32'(last_pop_cyc), 32'(first_rv_cyc + 2));

        // Oversized arsize clamps to 4-byte steps.
        nm = n_mar;
        exp_beat(32'h7FFF_FFE7, 2'b00, 1'b0, 4'd12);
        exp_beat(32'h7FFF_FFE3, 2'b00, 1'b1, 4'd12);
        issue_ar(32'h8000_0018, 8'd1, 3'd3, 2'b01, 4'd12);
        wait_done();
        chk("clamp_no_mem_ar", 32'(n_mar), 32'(nm));

        // i_flush pulse during a refill.
        flush_beat = 1;
        exp_ar(32'h8000_4000, 4'd13);
        exp_beat(32'h7FFF_BFFF, 2'b00, 1'b1, 4'd13);
        issue_ar(32'h8000_4000, 8'd0, 3'd2, 2'b01, 4'd13);
        wait_done();
        flush_beat = -1;
        nm = n_mar;
`ifdef ICACHE_FLUSH_EN
        exp_ar(32'h8000_4000, 4'd14);
`endif
        exp_beat(32'h7FFF_BFFB, 2'b00, 1'b1, 4'd14);
        issue_ar(32'h8000_4004, 8'd0, 3'd2, 2'b01, 4'd14);
        wait_done();
`ifdef ICACHE_FLUSH_EN
        chk("flush_forces_miss", 32'(n_mar), 32'(nm + 1));
`else
        chk("flush_ignored_hit", 32'(n_mar), 32'(nm));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
